// File: rtl/sid_pkg.sv
// Shared types for the SID bus initiator: register-sized fields, the
// latched bus request, and the bus master state encoding.
package sid_pkg;

    typedef logic [4:0] reg5_t;
    typedef logic [7:0] reg8_t;

    typedef struct packed {
        logic  write;
        reg5_t addr;
        reg8_t data;
    } sid_bus_req_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACCESS,
        RESET
    } bus_master_state_t;

endpackage

// File: rtl/sid_phi2_gen.sv
// Free-running phi2 phase counter. phi2 is registered so that it is low
// for the first half of the count and high for the second half, aligned
// with cnt.
module sid_phi2_gen #(
    parameter  int PHI2_DIV = 24,
    localparam int CNT_W    = $clog2(PHI2_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             phi2,
    output logic             boundary,
    output logic             phi2_rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHI2_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(PHI2_DIV / 2);

    logic [CNT_W-1:0] cnt_nxt;

    // Next phase value, wrapping at the end of the phi2 period.
    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Phase counter and phi2, both derived from the same next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            phi2 <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            phi2 <= (cnt_nxt >= HALF);
        end
    end

    assign boundary  = (cnt == LAST);
    assign phi2_rise = (cnt == HALF - 1'b1);

endmodule

// File: rtl/sid_bus_master.sv
// SID bus initiator: runs single register read/write cycles aligned to
// phi2 periods and issues res_n pulses on command.
module sid_bus_master
    import sid_pkg::*;
#(
    parameter int PHI2_DIV     = 24,
    parameter int RESET_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       res_req,
    output logic       phi2,
    output logic [4:0] addr,
    output logic       r_w_n,
    output logic       cs_n,
    output logic       res_n,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i
);

    localparam int CNT_W = $clog2(PHI2_DIV);
    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(PHI2_DIV / 2);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);

    bus_master_state_t state, state_nxt;
    sid_bus_req_t      req_in, req_q;
    logic [CNT_W-1:0]  cnt;
    logic [RC_W-1:0]   rst_cnt;
    logic              boundary, phi2_rise;
    logic              pend_rst, accept, enter_access;

    sid_phi2_gen #(.PHI2_DIV(PHI2_DIV)) u_phi2 (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .phi2      (phi2),
        .boundary  (boundary),
        .phi2_rise (phi2_rise)
    );

    assign req_in       = {req_write, req_addr, req_data};
    assign accept       = (state == IDLE) && req_valid && !res_req;
    assign enter_access = (state_nxt == ACCESS) && (state != ACCESS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; a command taken on the boundary clk skips PEND so the
    // new phi2 period still begins at cnt 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (res_req)        state_nxt = boundary ? RESET : PEND;
                else if (req_valid) state_nxt = boundary ? ACCESS : PEND;
            end
            PEND: begin
                if (boundary) state_nxt = pend_rst ? RESET : ACCESS;
            end
            ACCESS: begin
                if (boundary) state_nxt = IDLE;
            end
            RESET: begin
                if (boundary && (rst_cnt == RC_LAST)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus strobes decoded from state; they only move on state changes,
    // which happen at boundaries, so cs_n and r_w_n change at cnt 0.
    always_comb begin
        req_ready = (state == IDLE) && !res_req;
        cs_n      = (state != ACCESS);
        r_w_n     = !((state == ACCESS) && req_q.write);
        res_n     = (state != RESET);
        data_oe   = (state == ACCESS) && req_q.write && (cnt >= HALF);
    end

    // Response, bus address/data registers and reset pulse counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            addr      <= '0;
            data_o    <= '0;
            pend_rst  <= 1'b0;
            rst_cnt   <= '0;
        end else begin
            rsp_valid <= (state == ACCESS) && boundary;
            if ((state == ACCESS) && boundary && !req_q.write)
                rsp_data <= data_i;
            if (enter_access)
                addr <= (state == IDLE) ? req_in.addr : req_q.addr;
            if ((state == ACCESS) && req_q.write && phi2_rise)
                data_o <= req_q.data;
            if (state == IDLE)
                pend_rst <= res_req;
            if (state != RESET)
                rst_cnt <= '0;
            else if (boundary)
                rst_cnt <= rst_cnt + 1'b1;
        end
    end

    // Request latch, loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) req_q <= req_in;
    end

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master with PHI2_DIV=24, RESET_CYCLES=10.
module tb_sid_bus_master;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, req_write, rsp_valid, res_req;
    logic [4:0] req_addr, addr;
    logic [7:0] req_data, rsp_data, data_o, data_i;
    logic       phi2, r_w_n, cs_n, res_n, data_oe;

    int n_chk = 0, n_pass = 0;
    int tb_cnt = 0;

    // observation statistics
    int st_cs_low, st_first_low, st_first_low_cnt, st_rwn_low, st_addr_bad;
    int st_oe, st_oe_bad, st_do_bad, st_phi_bad, st_rsp, st_rsp_cnt, st_rsp_idx;
    int st_resn_low, st_resn_first, st_acc, st_acc_cnt, st_win, st_win_bad, st_gap_bad;
    int feed = 0;
    logic drive_rd = 1'b0, drop = 1'b0;
    logic [4:0] exp_addr;
    logic [7:0] exp_data;

    always #5 clk = ~clk;

    // reference phase counter
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 23) ? 0 : tb_cnt + 1;
    end

    sid_bus_master #(.PHI2_DIV(24), .RESET_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .res_req(res_req),
        .phi2(phi2), .addr(addr), .r_w_n(r_w_n), .cs_n(cs_n), .res_n(res_n),
        .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_cnt(input int k);
        int i;
        i = 0;
        while (tb_cnt != k && i < 60) begin
            tick();
            i++;
        end
        if (tb_cnt != k) chk("wait_cnt", tb_cnt, k);
    endtask

    task automatic post_req(input logic w, input logic [4:0] a, input logic [7:0] d);
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        exp_addr = a; exp_data = d;
    endtask

    task automatic observe(input int ncyc);
        logic prev_cs;
        int low_len, gap_len;
        st_cs_low = 0; st_first_low = -1; st_first_low_cnt = -1; st_rwn_low = 0;
        st_addr_bad = 0; st_oe = 0; st_oe_bad = 0; st_do_bad = 0; st_phi_bad = 0;
        st_rsp = 0; st_rsp_cnt = -1; st_rsp_idx = -1; st_resn_low = 0; st_resn_first = -1;
        st_acc = 0; st_acc_cnt = -1; st_win = 0; st_win_bad = 0; st_gap_bad = 0;
        low_len = 0; gap_len = 0; drop = 1'b0;
        prev_cs = cs_n;
        if (req_valid && req_ready) begin drop = 1'b1; st_acc++; st_acc_cnt = tb_cnt; end
        data_i = (drive_rd && tb_cnt == 23) ? 8'hA5 : 8'h00;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            res_req = 1'b0;
            if (drop) begin req_valid = 1'b0; drop = 1'b0; end
            if (!cs_n) begin
                st_cs_low++;
                if (st_first_low < 0) begin st_first_low = k; st_first_low_cnt = tb_cnt; end
                if (!r_w_n) st_rwn_low++;
                if (addr != exp_addr) st_addr_bad++;
            end
            if (data_oe) begin
                st_oe++;
                if (cs_n || tb_cnt < 12) st_oe_bad++;
                if (data_o != exp_data) st_do_bad++;
            end
            if (phi2 != (tb_cnt >= 12)) st_phi_bad++;
            if (rsp_valid) begin st_rsp++; st_rsp_cnt = tb_cnt; st_rsp_idx = k; end
            if (!res_n) begin
                st_resn_low++;
                if (st_resn_first < 0) st_resn_first = tb_cnt;
            end
            if (prev_cs && !cs_n) begin
                if (st_win > 0 && gap_len != 24) st_gap_bad++;
                st_win++; low_len = 1;
            end else if (!cs_n) low_len++;
            else if (!prev_cs) begin
                if (low_len != 24) st_win_bad++;
                gap_len = 1;
            end else gap_len++;
            prev_cs = cs_n;
            if (rsp_valid && feed > 0) begin feed--; req_valid = 1'b1; end
            if (req_valid && req_ready) begin drop = 1'b1; st_acc++; st_acc_cnt = tb_cnt; end
            data_i = (drive_rd && tb_cnt == 23) ? 8'hA5 : 8'h00;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        res_req = 1'b0; data_i = '0; exp_addr = '0; exp_data = '0;
        repeat (3) tick();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_r_w_n", r_w_n, 1);
        chk("rst_res_n", res_n, 1);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_phi2", phi2, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_rsp", {rsp_valid, rsp_data}, 0);
        chk("rst_ready", req_ready, 1);
        rst = 1'b0;

        // write 0x0F to 0x18
        wait_cnt(5);
        post_req(1'b1, 5'h18, 8'h0F);
        observe(60);
        chk("wr_acc", st_acc, 1);
        chk("wr_cs_low", st_cs_low, 24);
        chk("wr_cs_start", st_first_low_cnt, 0);
        chk("wr_rwn_low", st_rwn_low, 24);
        chk("wr_addr_bad", st_addr_bad, 0);
        chk("wr_oe_cnt", st_oe, 12);
        chk("wr_oe_bad", st_oe_bad, 0);
        chk("wr_do_bad", st_do_bad, 0);
        chk("wr_rsp", st_rsp, 1);
        chk("wr_rsp_cnt", st_rsp_cnt, 0);
        chk("wr_latency", st_rsp_idx <= 48, 1);
        chk("wr_phi", st_phi_bad, 0);

        // read 0x1B, data_i=0xA5 only at cnt 23
        wait_cnt(10);
        drive_rd = 1'b1;
        post_req(1'b0, 5'h1B, 8'h00);
        observe(60);
        drive_rd = 1'b0;
        chk("rd_cs_low", st_cs_low, 24);
        chk("rd_rwn_low", st_rwn_low, 0);
        chk("rd_addr_bad", st_addr_bad, 0);
        chk("rd_oe", st_oe, 0);
        chk("rd_rsp", st_rsp, 1);
        chk("rd_data", rsp_data, 8'hA5);

        // request offered on the boundary clk
        wait_cnt(23);
        post_req(1'b1, 5'h02, 8'h11);
        observe(40);
        chk("b23_first_low", st_first_low, 1);
        chk("b23_rsp", st_rsp, 1);

        // request offered at cnt 0
        wait_cnt(0);
        post_req(1'b1, 5'h03, 8'h22);
        observe(60);
        chk("b0_first_low", st_first_low, 24);
        chk("b0_first_cnt", st_first_low_cnt, 0);
        chk("b0_rsp", st_rsp, 1);

        // reset command together with a bus request
        wait_cnt(7);
        res_req = 1'b1;
        post_req(1'b1, 5'h04, 8'h55);
        #1;
        chk("res_ready", req_ready, 0);
        observe(330);
        chk("res_low", st_resn_low, 240);
        chk("res_first_cnt", st_resn_first, 0);
        chk("res_acc", st_acc, 1);
        chk("res_acc_cnt", st_acc_cnt, 0);
        chk("res_cs_low", st_cs_low, 24);
        chk("res_rsp", st_rsp, 1);
        chk("res_end", res_n, 1);

        // rst in the middle of a write
        wait_cnt(3);
        post_req(1'b1, 5'h05, 8'h66);
        #1;
        chk("abort_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        begin
            int i;
            i = 0;
            while (!(cs_n == 1'b0 && tb_cnt == 15) && i < 60) begin tick(); i++; end
        end
        chk("abort_reach", tb_cnt, 15);
        chk("abort_oe_before", data_oe, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_oe", data_oe, 0);
        chk("abort_phi2", phi2, 0);
        chk("abort_rsp", rsp_valid, 0);
        observe(60);
        chk("abort_no_rsp", st_rsp, 0);
        chk("abort_no_cs", st_cs_low, 0);
        chk("abort_phi", st_phi_bad, 0);

        // three back-to-back writes
        wait_cnt(4);
        post_req(1'b1, 5'h06, 8'h3C);
        feed = 2;
        observe(150);
        chk("b2b_win", st_win, 3);
        chk("b2b_win_len", st_win_bad, 0);
        chk("b2b_gap", st_gap_bad, 0);
        chk("b2b_cs_low", st_cs_low, 72);
        chk("b2b_rsp", st_rsp, 3);
        chk("b2b_phi", st_phi_bad, 0);
        chk("b2b_do_bad", st_do_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
